// File: rtl/d_cache_write_buffer.sv
// Posted-store FIFO between the D-cache store path and the RAM write port.
// Coalesces stores to the youngest entry and flags misses whose block still has stores pending.
module d_cache_write_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        store_valid,
  input  logic [15:0] store_address,
  input  logic [15:0] store_data,
  output logic        store_ready,
  input  logic        ram_busy,
  output logic        ram_write,
  output logic [15:0] ram_write_address,
  output logic [15:0] ram_write_data,
  input  logic        d_cache_miss,
  input  logic [15:0] d_cache_miss_address,
  output logic        block_conflict,
  output logic        empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [15:1]   entry_addr  [DEPTH];
  logic [15:0]   entry_data  [DEPTH];
  logic [DEPTH-1:0] entry_valid;

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] youngest;
  logic [CW-1:0] count;

  logic full;
  logic pop;
  logic coalesce_hit;
  logic accept;
  logic do_push;
  logic do_coalesce;
  logic conflict;

  // Byte-select bit of the store and the word/offset bits of the miss never matter.
  logic unused_bits;
  assign unused_bits = &{1'b0, store_address[0], d_cache_miss_address[3:0]};

  assign youngest = tail - PW'(1);
  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));

  assign ram_write = ~empty & ~ram_busy;
  assign pop       = ram_write;

  // The youngest entry can absorb a store unless it is the head leaving this cycle.
  assign coalesce_hit = ~empty
                      & entry_valid[youngest]
                      & (entry_addr[youngest] == store_address[15:1])
                      & ~(pop & (count == CW'(1)));

  assign store_ready = ~full | pop | coalesce_hit;
  assign accept      = store_valid & store_ready;
  assign do_coalesce = accept & coalesce_hit;
  assign do_push     = accept & ~coalesce_hit;

  assign ram_write_address = empty ? 16'h0000 : {entry_addr[head], 1'b0};
  assign ram_write_data    = empty ? 16'h0000 : entry_data[head];

  always_comb begin
    conflict = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i]
          && (entry_addr[i][15:4] == d_cache_miss_address[15:4])
          && !(pop && (PW'(i) == head)))
        conflict = 1'b1;
    end
  end

  assign block_conflict = d_cache_miss & conflict;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop)
        head <= head + PW'(1);
      if (do_push)
        tail <= tail + PW'(1);
      case ({do_push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // When full with a same-cycle pop, tail equals head: the push must win the valid bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_addr[i] <= '0;
        entry_data[i] <= '0;
      end
    end else begin
      if (pop)
        entry_valid[head] <= 1'b0;
      if (do_push) begin
        entry_valid[tail] <= 1'b1;
        entry_addr[tail]  <= store_address[15:1];
        entry_data[tail]  <= store_data;
      end
      if (do_coalesce)
        entry_data[youngest] <= store_data;
    end
  end

endmodule

// File: tb/tb_d_cache_write_buffer.sv
// Self-checking bench for d_cache_write_buffer: a queue model of the FIFO acts as
// scoreboard; stores are pushed on acceptance and popped when the RAM write retires.
module tb_d_cache_write_buffer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        store_valid;
  logic [15:0] store_address;
  logic [15:0] store_data;
  logic        store_ready;
  logic        ram_busy;
  logic        ram_write;
  logic [15:0] ram_write_address;
  logic [15:0] ram_write_data;
  logic        d_cache_miss;
  logic [15:0] d_cache_miss_address;
  logic        block_conflict;
  logic        empty;

  int checks;
  int fails;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } entry_t;

  entry_t mq[$];

  d_cache_write_buffer #(.DEPTH(DEPTH)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .store_valid          (store_valid),
    .store_address        (store_address),
    .store_data           (store_data),
    .store_ready          (store_ready),
    .ram_busy             (ram_busy),
    .ram_write            (ram_write),
    .ram_write_address    (ram_write_address),
    .ram_write_data       (ram_write_data),
    .d_cache_miss         (d_cache_miss),
    .d_cache_miss_address (d_cache_miss_address),
    .block_conflict       (block_conflict),
    .empty                (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic m_write();
    return (mq.size() != 0) && !ram_busy;
  endfunction

  function automatic logic m_match();
    if (mq.size() == 0) return 1'b0;
    return (mq[mq.size()-1].addr == {store_address[15:1], 1'b0})
           && !(m_write() && mq.size() == 1);
  endfunction

  function automatic logic m_ready();
    return (mq.size() < DEPTH) || m_write() || m_match();
  endfunction

  function automatic logic m_conflict();
    logic hit;
    hit = 1'b0;
    for (int i = (m_write() ? 1 : 0); i < mq.size(); i++)
      if (mq[i].addr[15:4] == d_cache_miss_address[15:4]) hit = 1'b1;
    return d_cache_miss && hit;
  endfunction

  // {ram_write, address, data, empty, store_ready, block_conflict}
  function automatic logic [35:0] m_outputs();
    logic [15:0] a;
    logic [15:0] d;
    a = (mq.size() != 0) ? mq[0].addr : 16'h0000;
    d = (mq.size() != 0) ? mq[0].data : 16'h0000;
    return {m_write(), a, d, (mq.size() == 0), m_ready(), m_conflict()};
  endfunction

  function automatic logic [35:0] dut_outputs();
    return {ram_write, ram_write_address, ram_write_data, empty, store_ready, block_conflict};
  endfunction

  task automatic model_step();
    logic   pop;
    logic   hit;
    entry_t e;
    if (!rst_n) begin
      mq.delete();
      return;
    end
    pop = m_write();
    hit = m_match();
    if (store_valid && m_ready()) begin
      if (hit) begin
        e = mq[mq.size()-1];
        e.data = store_data;
        mq[mq.size()-1] = e;
      end else begin
        e.addr = {store_address[15:1], 1'b0};
        e.data = store_data;
        mq.push_back(e);
      end
    end
    if (pop) void'(mq.pop_front());
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] d,
                       input logic busy);
    store_valid   = v;
    store_address = a;
    store_data    = d;
    ram_busy      = busy;
  endtask

  task automatic test_reset();
    logic [35:0] exp;
    rst_n = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    d_cache_miss = 1'b1;
    d_cache_miss_address = 16'h0040;
    repeat (2) tick();
    #1;
    exp = {1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0};
    checks++;
    if (dut_outputs() !== exp) begin
      fails++;
      $display("[TB] FAIL reset_values: got %h, expected %h", dut_outputs(), exp);
    end
    d_cache_miss = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_drain();
    logic [15:0] addrs [4];
    logic [15:0] datas [4];
    int first_write;
    int n_writes;
    int last_write;
    addrs = '{16'h0010, 16'h0012, 16'h0014, 16'h0016};
    datas = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
    first_write = -1;
    n_writes = 0;
    last_write = -1;
    for (int c = 0; c < 8; c++) begin
      if (c < 4) drive(1'b1, addrs[c], datas[c], 1'b0);
      else       drive(1'b0, 16'h0, 16'h0, 1'b0);
      #1;
      checks++;
      if (dut_outputs() !== m_outputs()) begin
        fails++;
        $display("[TB] FAIL basic_outputs cycle %0d: got %h, expected %h", c, dut_outputs(), m_outputs());
      end
      if (ram_write === 1'b1) begin
        if (first_write < 0) first_write = c;
        last_write = c;
        n_writes++;
      end
      tick();
    end
    checks++;
    if (first_write != 1 || last_write != 4 || n_writes != 4) begin
      fails++;
      $display("[TB] FAIL basic_write_window: got first %0d last %0d n %0d, expected 1 4 4",
               first_write, last_write, n_writes);
    end
    checks++;
    if (empty !== 1'b1) begin
      fails++;
      $display("[TB] FAIL basic_empty: got %b, expected 1", empty);
    end
  endtask

  task automatic test_full_backpressure();
    int seen_fifth;
    seen_fifth = 0;
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 16'h0100 + 16'(2 * c), 16'h5000 + 16'(c), 1'b1);
      #1;
      checks++;
      if (dut_outputs() !== m_outputs()) begin
        fails++;
        $display("[TB] FAIL full_fill cycle %0d: got %h, expected %h", c, dut_outputs(), m_outputs());
      end
      tick();
    end
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 16'h0108, 16'h5004, 1'b1);
      #1;
      checks++;
      if (store_ready !== 1'b0) begin
        fails++;
        $display("[TB] FAIL full_not_ready cycle %0d: got %b, expected 0", c, store_ready);
      end
      tick();
    end
    drive(1'b1, 16'h0108, 16'h5004, 1'b0);
    #1;
    checks++;
    if ({store_ready, ram_write, ram_write_address} !== {1'b1, 1'b1, 16'h0100}) begin
      fails++;
      $display("[TB] FAIL full_accept_on_pop: got ready %b write %b addr %h, expected 1 1 0100",
               store_ready, ram_write, ram_write_address);
    end
    tick();
    for (int c = 0; c < 2 * DEPTH + 4 && !(mq.size() == 0 && empty === 1'b1); c++) begin
      drive(1'b0, 16'h0, 16'h0, 1'b0);
      #1;
      checks++;
      if (dut_outputs() !== m_outputs()) begin
        fails++;
        $display("[TB] FAIL full_drain cycle %0d: got %h, expected %h", c, dut_outputs(), m_outputs());
      end
      if (ram_write === 1'b1 && ram_write_address === 16'h0108 && ram_write_data === 16'h5004)
        seen_fifth++;
      tick();
    end
    checks++;
    if (seen_fifth != 1 || empty !== 1'b1) begin
      fails++;
      $display("[TB] FAIL full_fifth_retired: got %0d writes empty %b, expected 1 writes empty 1",
               seen_fifth, empty);
    end
  endtask

  task automatic test_coalesce();
    drive(1'b1, 16'h0020, 16'h1111, 1'b1);
    tick();
    drive(1'b1, 16'h0021, 16'h2222, 1'b1);
    #1;
    checks++;
    if (dut_outputs() !== m_outputs()) begin
      fails++;
      $display("[TB] FAIL coalesce_accept: got %h, expected %h", dut_outputs(), m_outputs());
    end
    tick();
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    #1;
    checks++;
    if ({ram_write, ram_write_address, ram_write_data} !== {1'b1, 16'h0020, 16'h2222}) begin
      fails++;
      $display("[TB] FAIL coalesce_write: got %b %h %h, expected 1 0020 2222",
               ram_write, ram_write_address, ram_write_data);
    end
    tick();
    #1;
    checks++;
    if ({ram_write, empty} !== 2'b01) begin
      fails++;
      $display("[TB] FAIL coalesce_single: got write %b empty %b, expected 0 1", ram_write, empty);
    end
  endtask

  task automatic test_block_conflict();
    drive(1'b1, 16'h0046, 16'h4646, 1'b1);
    d_cache_miss = 1'b1;
    d_cache_miss_address = 16'h0040;
    #1;
    checks++;
    if (block_conflict !== 1'b0) begin
      fails++;
      $display("[TB] FAIL conflict_same_cycle_push: got %b, expected 0", block_conflict);
    end
    tick();
    drive(1'b0, 16'h0, 16'h0, 1'b1);
    #1;
    checks++;
    if (block_conflict !== 1'b1) begin
      fails++;
      $display("[TB] FAIL conflict_pending: got %b, expected 1", block_conflict);
    end
    d_cache_miss_address = 16'h0050;
    #1;
    checks++;
    if (block_conflict !== 1'b0) begin
      fails++;
      $display("[TB] FAIL conflict_other_block: got %b, expected 0", block_conflict);
    end
    d_cache_miss_address = 16'h004E;
    ram_busy = 1'b0;
    #1;
    checks++;
    if (dut_outputs() !== m_outputs()) begin
      fails++;
      $display("[TB] FAIL conflict_pop_cycle: got %h, expected %h", dut_outputs(), m_outputs());
    end
    tick();
    #1;
    checks++;
    if ({block_conflict, empty} !== 2'b01) begin
      fails++;
      $display("[TB] FAIL conflict_after_pop: got bc %b empty %b, expected 0 1", block_conflict, empty);
    end
    d_cache_miss = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 16'h0200 + 16'(2 * c), 16'hB000 + 16'(c), 1'b1);
      tick();
    end
    for (int c = 0; c < 20; c++) begin
      drive(1'b1, 16'h0208 + 16'(2 * c), 16'(($urandom & 16'hFFF0) | c), 1'b0);
      #1;
      checks++;
      if (dut_outputs() !== m_outputs() || store_ready !== 1'b1) begin
        fails++;
        $display("[TB] FAIL wrap_stream cycle %0d: got %h, expected %h (ready must be 1)",
                 c, dut_outputs(), m_outputs());
      end
      tick();
    end
    for (int c = 0; c < 2 * DEPTH + 4 && !(mq.size() == 0 && empty === 1'b1); c++) begin
      drive(1'b0, 16'h0, 16'h0, 1'b0);
      #1;
      checks++;
      if (dut_outputs() !== m_outputs()) begin
        fails++;
        $display("[TB] FAIL wrap_drain cycle %0d: got %h, expected %h", c, dut_outputs(), m_outputs());
      end
      tick();
    end
    checks++;
    if (empty !== 1'b1 || mq.size() != 0) begin
      fails++;
      $display("[TB] FAIL wrap_empty: got empty %b model %0d left, expected 1 and 0", empty, mq.size());
    end
  endtask

  task automatic test_random();
    logic [15:0] pool [4];
    pool = '{16'h0300, 16'h0302, 16'h0310, 16'h0340};
    for (int c = 0; c < 80; c++) begin
      drive(($urandom_range(0, 3) != 0), pool[$urandom_range(0, 3)], 16'($urandom),
            ($urandom_range(0, 2) == 0));
      d_cache_miss = $urandom_range(0, 1) == 1;
      d_cache_miss_address = pool[$urandom_range(0, 3)] | 16'($urandom_range(0, 15));
      #1;
      checks++;
      if (dut_outputs() !== m_outputs()) begin
        fails++;
        $display("[TB] FAIL random cycle %0d: got %h, expected %h", c, dut_outputs(), m_outputs());
      end
      tick();
    end
    d_cache_miss = 1'b0;
    for (int c = 0; c < 2 * DEPTH + 4 && !(mq.size() == 0 && empty === 1'b1); c++) begin
      drive(1'b0, 16'h0, 16'h0, 1'b0);
      tick();
    end
    checks++;
    if (empty !== 1'b1 || mq.size() != 0) begin
      fails++;
      $display("[TB] FAIL random_drain: got empty %b model %0d left, expected 1 and 0", empty, mq.size());
    end
  endtask

  task automatic test_reset_mid_drain();
    logic [35:0] exp;
    int late_writes;
    late_writes = 0;
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 16'h0400 + 16'(2 * c), 16'hC000 + 16'(c), 1'b1);
      tick();
    end
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    d_cache_miss = 1'b1;
    d_cache_miss_address = 16'h0402;
    #1;
    checks++;
    if ({ram_write, block_conflict} !== 2'b11) begin
      fails++;
      $display("[TB] FAIL pre_reset_pending: got write %b bc %b, expected 1 1", ram_write, block_conflict);
    end
    #2;
    rst_n = 1'b0;
    mq.delete();
    #1;
    exp = {1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0};
    checks++;
    if (dut_outputs() !== exp) begin
      fails++;
      $display("[TB] FAIL async_reset_values: got %h, expected %h", dut_outputs(), exp);
    end
    tick();
    rst_n = 1'b1;
    d_cache_miss = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (ram_write !== 1'b0) late_writes++;
      tick();
    end
    checks++;
    if (late_writes != 0 || empty !== 1'b1) begin
      fails++;
      $display("[TB] FAIL post_reset_writes: got %0d writes empty %b, expected 0 writes empty 1",
               late_writes, empty);
    end
  endtask

  initial begin
    checks = 0;
    fails = 0;
    rst_n = 1'b0;
    store_valid = 1'b0;
    store_address = '0;
    store_data = '0;
    ram_busy = 1'b0;
    d_cache_miss = 1'b0;
    d_cache_miss_address = '0;
    @(negedge clk);
    test_reset();
    test_basic_drain();
    test_full_backpressure();
    test_coalesce();
    test_block_conflict();
    test_back_to_back();
    test_random();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
